// File: rtl/mni_wb_rx_if.sv
// Bundle of the three channels of the writeback receiver:
// the halfword input stream, the memory write port and the acknowledge port.
interface mni_wb_rx_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_stall;
  logic        mem_wr_valid;
  logic        mem_wr_stall;
  logic [31:0] mem_wr_adr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_last;
  logic        ack_valid;
  logic        ack_stall;
  logic [31:0] ack_adr;

  modport slave (
    input  in_valid, in_data, mem_wr_stall, ack_stall,
    output in_stall, mem_wr_valid, mem_wr_adr, mem_wr_data, mem_wr_last,
           ack_valid, ack_adr
  );

  modport master (
    output in_valid, in_data, mem_wr_stall, ack_stall,
    input  in_stall, mem_wr_valid, mem_wr_adr, mem_wr_data, mem_wr_last,
           ack_valid, ack_adr
  );
endinterface

// File: rtl/mni_wb_rx.sv
// Writeback packet receiver: turns the 16-bit packet stream back into
// line-aligned 32-bit memory writes, then acknowledges with the reply address.
module mni_wb_rx #(
  parameter int WORDS_LOG2 = 4
) (
  input  logic         clk_ni,
  input  logic         rst_ni,
  mni_wb_rx_if.slave   bus
);

  localparam int WORDS    = 1 << WORDS_LOG2;
  localparam int LINE_LSB = WORDS_LOG2 + 2;
  localparam logic [WORDS_LOG2-1:0] LAST_IDX = WORDS_LOG2'(WORDS - 1);

  typedef enum logic [6:0] {
    IDLE      = 7'b0000001,
    ADR_LOW   = 7'b0000010,
    REP_HIGH  = 7'b0000100,
    REP_LOW   = 7'b0001000,
    DATA_HIGH = 7'b0010000,
    DATA_LOW  = 7'b0100000,
    ACK       = 7'b1000000
  } state_t;

  state_t                  state_q;
  // Only the line-aligned part of the address is kept; the offset bits are dropped.
  logic [31:LINE_LSB]      adr_q;
  logic [31:0]             rep_q;
  logic [15:0]             hi_q;
  logic [WORDS_LOG2-1:0]   widx_q;
  logic                    wr_valid_q;
  logic [31:0]             wr_adr_q;
  logic [31:0]             wr_data_q;
  logic                    wr_last_q;
  logic                    ack_valid_q;
  logic [31:0]             ack_adr_q;

  logic in_stall;
  logic in_fire;
  logic wr_fire;
  logic ack_fire;
  logic last_word;

  // A new word may load in the same cycle the pending one drains.
  assign in_stall  = (state_q == ACK) |
                     ((state_q == DATA_LOW) & wr_valid_q & bus.mem_wr_stall);
  assign in_fire   = bus.in_valid & ~in_stall;
  assign wr_fire   = wr_valid_q & ~bus.mem_wr_stall;
  assign ack_fire  = ack_valid_q & ~bus.ack_stall;
  assign last_word = (widx_q == LAST_IDX);

  always_ff @(posedge clk_ni or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      rep_q       <= '0;
      hi_q        <= '0;
      widx_q      <= '0;
      wr_valid_q  <= 1'b0;
      wr_adr_q    <= '0;
      wr_data_q   <= '0;
      wr_last_q   <= 1'b0;
      ack_valid_q <= 1'b0;
      ack_adr_q   <= '0;
    end else begin
      if (wr_fire) begin
        wr_valid_q <= 1'b0;
      end
      if (ack_fire) begin
        ack_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          widx_q <= '0;
          if (in_fire) begin
            adr_q[31:16] <= bus.in_data;
            state_q      <= ADR_LOW;
          end
        end
        ADR_LOW: begin
          if (in_fire) begin
            adr_q[15:LINE_LSB] <= bus.in_data[15:LINE_LSB];
            state_q            <= REP_HIGH;
          end
        end
        REP_HIGH: begin
          if (in_fire) begin
            rep_q[31:16] <= bus.in_data;
            state_q      <= REP_LOW;
          end
        end
        REP_LOW: begin
          if (in_fire) begin
            rep_q[15:0] <= bus.in_data;
            state_q     <= DATA_HIGH;
          end
        end
        DATA_HIGH: begin
          if (in_fire) begin
            hi_q    <= bus.in_data;
            state_q <= DATA_LOW;
          end
        end
        DATA_LOW: begin
          if (in_fire) begin
            wr_valid_q <= 1'b1;
            wr_adr_q   <= {adr_q, widx_q, 2'b00};
            wr_data_q  <= {hi_q, bus.in_data};
            wr_last_q  <= last_word;
            widx_q     <= widx_q + 1'b1;
            state_q    <= last_word ? ACK : DATA_HIGH;
          end
        end
        ACK: begin
          // Raise the ack as soon as the final write has left the output register.
          if (ack_fire) begin
            state_q <= IDLE;
          end else if (!ack_valid_q && (!wr_valid_q || wr_fire)) begin
            ack_valid_q <= 1'b1;
            ack_adr_q   <= rep_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_stall     = in_stall;
  assign bus.mem_wr_valid = wr_valid_q;
  assign bus.mem_wr_adr   = wr_adr_q;
  assign bus.mem_wr_data  = wr_data_q;
  assign bus.mem_wr_last  = wr_last_q;
  assign bus.ack_valid    = ack_valid_q;
  assign bus.ack_adr      = ack_adr_q;

endmodule

// File: tb/tb_mni_wb_rx.sv
// Scoreboard bench for mni_wb_rx: directed packets push expected writes/acks,
// an independent monitor pops and compares whatever the DUT presents.
module tb_mni_wb_rx;

  logic clk_ni = 1'b0;
  logic rst_ni = 1'b0;

  mni_wb_rx_if bus();

  mni_wb_rx #(.WORDS_LOG2(4)) dut (
    .clk_ni (clk_ni),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_ni = ~clk_ni;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] ack_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int in_stall_cycles = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int last_wr_cyc = 0;
  int ack_acc_cyc = 0;
  int wr_count = 0;
  int ack_count = 0;
  bit exact_ack = 1'b0;
  bit chk_b2b = 1'b0;
  int mem_mode = 0;
  int ack_mode = 0;
  int mem_cnt = 0;
  int acnt = 0;
  bit done3 = 1'b0;

  always @(posedge clk_ni) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send_hw(input logic [15:0] d, output int acc_cyc);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk_ni);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      #1;
      if (!bus.in_stall) begin
        done = 1'b1;
      end else begin
        in_stall_cycles++;
        n++;
        if (n > 5000) begin
          $display("FAIL in_accept_timeout: halfword 0x%04h not accepted after %0d cycles", d, n);
          $fatal(1, "input acceptance timeout");
        end
      end
    end
    acc_cyc = cyc;
  endtask

  task automatic send_packet(input logic [31:0] adr, input logic [31:0] rep,
                             input logic [15:0] base, input bit gap, input int n_data);
    logic [15:0] hw [0:35];
    wr_t         e;
    int          c;
    hw[0] = adr[31:16];
    hw[1] = adr[15:0];
    hw[2] = rep[31:16];
    hw[3] = rep[15:0];
    for (int i = 0; i < 32; i++) hw[4+i] = base + 16'(i);
    for (int k = 0; k < n_data / 2; k++) begin
      e.adr  = {adr[31:6], 4'(k), 2'b00};
      e.data = {hw[4+2*k], hw[5+2*k]};
      e.last = (k == 15);
      wr_q.push_back(e);
    end
    if (n_data == 32) ack_q.push_back(rep);
    in_stall_cycles = 0;
    for (int i = 0; i < 4 + n_data; i++) begin
      send_hw(hw[i], c);
      if (i == 0) begin
        first_cyc = c;
        if (chk_b2b) begin
          chk("b2b_first_accept_cycle", 32'(c), 32'(ack_acc_cyc + 1));
          chk_b2b = 1'b0;
        end
      end
      last_cyc = c;
      if (gap) begin
        @(negedge clk_ni);
        bus.in_valid = 1'b0;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk_ni);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((wr_q.size() != 0 || ack_q.size() != 0 || bus.ack_valid || bus.mem_wr_valid) && n < 3000) begin
      @(negedge clk_ni);
      #3;
      n++;
    end
    chk("drain_within_bound", 32'(n < 3000), 32'd1);
  endtask

  // Back-pressure generators for the memory and ack ports.
  initial begin
    bus.mem_wr_stall = 1'b0;
    bus.ack_stall    = 1'b0;
    forever begin
      @(negedge clk_ni);
      case (mem_mode)
        1: begin
          if (mem_cnt > 0) begin
            bus.mem_wr_stall = 1'b1;
            mem_cnt--;
          end else if (bus.mem_wr_valid && bus.mem_wr_adr[5:2] == 4'd3 && !done3) begin
            bus.mem_wr_stall = 1'b1;
            mem_cnt = 4;
            done3 = 1'b1;
          end else begin
            bus.mem_wr_stall = 1'b0;
          end
        end
        2: bus.mem_wr_stall = 1'($urandom_range(0, 1));
        3: bus.mem_wr_stall = bus.mem_wr_valid && (bus.mem_wr_adr[5:2] == 4'd2);
        default: bus.mem_wr_stall = 1'b0;
      endcase
      case (ack_mode)
        1: begin
          if (bus.ack_valid && acnt < 10) begin
            bus.ack_stall = 1'b1;
            acnt++;
          end else begin
            bus.ack_stall = 1'b0;
          end
        end
        2: bus.ack_stall = 1'($urandom_range(0, 1));
        default: bus.ack_stall = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    bit          pw;
    bit          pa;
    bit          pav;
    logic [31:0] p_adr;
    logic [31:0] p_data;
    logic        p_last;
    logic [31:0] p_ack;
    wr_t         e;
    logic [31:0] ea;
    pw = 1'b0; pa = 1'b0; pav = 1'b0;
    p_adr = '0; p_data = '0; p_last = 1'b0; p_ack = '0;
    forever begin
      @(negedge clk_ni);
      #2;
      if (!rst_ni) begin
        pw = 1'b0; pa = 1'b0; pav = 1'b0;
        continue;
      end
      if (bus.mem_wr_valid || bus.ack_valid)
        chk("wr_ack_valid_overlap", 32'(bus.mem_wr_valid & bus.ack_valid), 32'd0);
      if (pw) begin
        chk("wr_hold_valid", 32'(bus.mem_wr_valid), 32'd1);
        chk("wr_hold_adr", bus.mem_wr_adr, p_adr);
        chk("wr_hold_data", bus.mem_wr_data, p_data);
        chk("wr_hold_last", 32'(bus.mem_wr_last), 32'(p_last));
      end
      if (pa) begin
        chk("ack_hold_valid", 32'(bus.ack_valid), 32'd1);
        chk("ack_hold_adr", bus.ack_adr, p_ack);
      end
      if (bus.ack_valid) chk("in_stall_during_ack", 32'(bus.in_stall), 32'd1);
      if (bus.ack_valid && !pav) begin
        if (exact_ack) chk("ack_latency", 32'(cyc - last_wr_cyc), 32'd1);
        else           chk("ack_after_last_write", 32'(cyc > last_wr_cyc), 32'd1);
      end
      if (bus.mem_wr_valid && !bus.mem_wr_stall) begin
        wr_count++;
        last_wr_cyc = cyc;
        if (wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got adr 0x%08h data 0x%08h, required none", bus.mem_wr_adr, bus.mem_wr_data);
        end else begin
          e = wr_q.pop_front();
          chk("wr_adr", bus.mem_wr_adr, e.adr);
          chk("wr_data", bus.mem_wr_data, e.data);
          chk("wr_last", 32'(bus.mem_wr_last), 32'(e.last));
        end
      end
      if (bus.ack_valid && !bus.ack_stall) begin
        ack_count++;
        ack_acc_cyc = cyc;
        if (ack_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: got adr 0x%08h, required none", bus.ack_adr);
        end else begin
          ea = ack_q.pop_front();
          chk("ack_adr", bus.ack_adr, ea);
        end
      end
      pw     = bus.mem_wr_valid && bus.mem_wr_stall;
      p_adr  = bus.mem_wr_adr;
      p_data = bus.mem_wr_data;
      p_last = bus.mem_wr_last;
      pa     = bus.ack_valid && bus.ack_stall;
      p_ack  = bus.ack_adr;
      pav    = bus.ack_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst_ni       = 1'b0;
    repeat (3) @(negedge clk_ni);
    #1;
    chk("reset_in_stall", 32'(bus.in_stall), 32'd0);
    chk("reset_wr_valid", 32'(bus.mem_wr_valid), 32'd0);
    chk("reset_ack_valid", 32'(bus.ack_valid), 32'd0);
    chk("reset_wr_adr", bus.mem_wr_adr, 32'd0);
    chk("reset_wr_data", bus.mem_wr_data, 32'd0);
    chk("reset_wr_last", 32'(bus.mem_wr_last), 32'd0);
    chk("reset_ack_adr", bus.ack_adr, 32'd0);
    @(negedge clk_ni);
    rst_ni = 1'b1;

    // Clean packet, no back-pressure.
    exact_ack = 1'b1;
    send_packet(32'h8000_1240, 32'h0000_ABCD, 16'h0000, 1'b0, 32);
    idle();
    chk("clean_in_stall_cycles", 32'(in_stall_cycles), 32'd0);
    chk("clean_span_cycles", 32'(last_cyc - first_cyc), 32'd35);
    wait_drain();
    exact_ack = 1'b0;

    // Same packet with input valid every other cycle.
    send_packet(32'h8000_1240, 32'h0000_ABCD, 16'h0000, 1'b1, 32);
    chk("gap_span_cycles", 32'(last_cyc - first_cyc), 32'd70);
    wait_drain();

    // Memory stall of 5 cycles on word 3.
    mem_mode = 1; done3 = 1'b0; mem_cnt = 0;
    send_packet(32'h4000_0A00, 32'h1234_5678, 16'h5000, 1'b0, 32);
    idle();
    chk("memstall_in_stall_cycles", 32'(in_stall_cycles), 32'd4);
    wait_drain();
    mem_mode = 0;

    // Ack held off for 10 cycles, next packet queued behind it.
    ack_mode = 1; acnt = 0;
    send_packet(32'h0000_0040, 32'hCAFE_0001, 16'h1000, 1'b0, 32);
    chk_b2b = 1'b1;
    send_packet(32'h0000_0080, 32'hCAFE_0002, 16'h2000, 1'b0, 32);
    idle();
    wait_drain();
    ack_mode = 0;

    // Reset after the 7th data halfword with word 2 pending.
    mem_mode = 3;
    send_packet(32'h1111_2200, 32'hDEAD_BEEF, 16'h0100, 1'b0, 7);
    @(negedge clk_ni);
    bus.in_valid = 1'b0;
    chk("rst_wr_pending_before", 32'(bus.mem_wr_valid), 32'd1);
    chk("rst_queue_pending_before", 32'(wr_q.size()), 32'd1);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("rst_async_wr_valid", 32'(bus.mem_wr_valid), 32'd0);
    chk("rst_async_ack_valid", 32'(bus.ack_valid), 32'd0);
    chk("rst_async_in_stall", 32'(bus.in_stall), 32'd0);
    wr_q.delete();
    ack_q.delete();
    mem_mode = 0;
    repeat (2) @(negedge clk_ni);
    rst_ni = 1'b1;
    wr_count = 0;
    ack_count = 0;
    send_packet(32'h2222_3300, 32'h0BAD_F00D, 16'h0300, 1'b0, 32);
    idle();
    wait_drain();
    chk("post_reset_write_count", 32'(wr_count), 32'd16);
    chk("post_reset_ack_count", 32'(ack_count), 32'd1);

    // Back-to-back packets under random memory and ack stalls.
    mem_mode = 2; ack_mode = 2;
    ack_count = 0;
    for (int p = 0; p < 4; p++) begin
      send_packet($urandom, $urandom, 16'($urandom), 1'b0, 32);
    end
    idle();
    wait_drain();
    mem_mode = 0; ack_mode = 0;
    chk("random_ack_count", 32'(ack_count), 32'd4);

    repeat (3) @(negedge clk_ni);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
